// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronises a raw button, debounces press and
// release, and emits a one-cycle advance pulse per press plus optional
// auto-repeat pulses while the button stays held.
module button_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int DB_W         = 3,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 3,
    parameter int RPT_W        = 4
) (
    input  logic       clk0,
    input  logic       rst,
    input  logic       button,
    output logic       btn_pulse,
    output logic       btn_level,
    output logic       btn_release,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REL_DB   = 3'd3
    } state_t;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    state_t           state;
    state_t           state_nx;
    logic             ff1;
    logic             ff2;
    logic             btn_s;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_cnt_nx;
    logic [RPT_W-1:0] hold_cnt;
    logic [RPT_W-1:0] hold_cnt_nx;
    logic [RPT_W-1:0] rpt_limit;
    logic             rpt_phase;
    logic             rpt_phase_nx;
    logic             pulse_nx;
    logic             level_nx;
    logic             release_nx;

    assign btn_s     = ff2;
    assign state_dbg = state;
    assign rpt_limit = rpt_phase ? RATE_LAST : DELAY_LAST;

    // Two-flop synchroniser; the only logic that ever touches the raw button.
    always_ff @(posedge clk0) begin
        if (rst) begin
            ff1 <= 1'b0;
            ff2 <= 1'b0;
        end else begin
            ff1 <= button;
            ff2 <= ff1;
        end
    end

    // State, counters and registered outputs all update together here.
    always_ff @(posedge clk0) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            rpt_phase   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_level   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nx;
            db_cnt      <= db_cnt_nx;
            hold_cnt    <= hold_cnt_nx;
            rpt_phase   <= rpt_phase_nx;
            btn_pulse   <= pulse_nx;
            btn_level   <= level_nx;
            btn_release <= release_nx;
        end
    end

    // Next-state logic: press/release debounce and hold-time repeat pacing.
    always_comb begin
        state_nx     = state;
        db_cnt_nx    = db_cnt;
        hold_cnt_nx  = hold_cnt;
        rpt_phase_nx = rpt_phase;
        pulse_nx     = 1'b0;
        release_nx   = 1'b0;
        level_nx     = btn_level;

        case (state)
            IDLE: begin
                level_nx = 1'b0;
                if (btn_s) begin
                    state_nx  = PRESS_DB;
                    db_cnt_nx = DB_ONE;
                end
            end

            PRESS_DB: begin
                level_nx = 1'b0;
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nx     = HELD;
                    pulse_nx     = 1'b1;
                    level_nx     = 1'b1;
                    hold_cnt_nx  = '0;
                    rpt_phase_nx = 1'b0;
                end else begin
                    db_cnt_nx = db_cnt + DB_ONE;
                end
            end

            HELD: begin
                level_nx = 1'b1;
                if (!btn_s) begin
                    state_nx  = REL_DB;
                    db_cnt_nx = DB_ONE;
                end else if (REPEAT_EN != 0) begin
                    if (hold_cnt == rpt_limit) begin
                        pulse_nx     = 1'b1;
                        hold_cnt_nx  = '0;
                        rpt_phase_nx = 1'b1;
                    end else begin
                        hold_cnt_nx = hold_cnt + RPT_W'(1);
                    end
                end
            end

            REL_DB: begin
                level_nx = 1'b1;
                if (btn_s) begin
                    state_nx = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_nx   = IDLE;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end else begin
                    db_cnt_nx = db_cnt + DB_ONE;
                end
            end

            default: begin
                state_nx = IDLE;
                level_nx = 1'b0;
            end
        endcase
    end

endmodule
